// File: rtl/issue_queue.sv
// Decoded-instruction buffer feeding the dual-issue unit: up to two enqueues and
// two retirements per cycle, oldest two entries exposed as head0/head1.
module issue_queue #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               enq0_valid,
  input  logic [ENTRY_W-1:0] enq0_data,
  input  logic               enq1_valid,
  input  logic [ENTRY_W-1:0] enq1_data,
  output logic               enq_ready,
  output logic               head0_valid,
  output logic [ENTRY_W-1:0] head0_data,
  output logic               head1_valid,
  output logic [ENTRY_W-1:0] head1_data,
  input  logic               issue0,
  input  logic               issue1,
  output logic [CW-1:0]      count,
  output logic               proto_err
);

  logic [DEPTH-1:0][ENTRY_W-1:0] r_mem;
  logic [PW-1:0]                 r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]                 r_count;
  logic                          r_proto_err;

  logic [CW-1:0] w_n_enq, w_n_deq;
  logic          w_enq_err, w_deq_err;
  logic [PW-1:0] w_rd_ptr1;

  assign w_rd_ptr1   = r_rd_ptr + PW'(1);
  assign head0_valid = (r_count != '0);
  assign head1_valid = (r_count >= CW'(2));
  assign head0_data  = head0_valid ? r_mem[r_rd_ptr]  : '0;
  assign head1_data  = head1_valid ? r_mem[w_rd_ptr1] : '0;
  // Ready looks only at registered occupancy so there is no issue->ready path.
  assign enq_ready   = (r_count <= CW'(DEPTH - 2));
  assign count       = r_count;
  assign proto_err   = r_proto_err;

  always_comb begin
    w_n_enq = '0;
    if (enq_ready && enq0_valid) w_n_enq = enq1_valid ? CW'(2) : CW'(1);
    w_enq_err = (enq1_valid && !enq0_valid) || ((enq0_valid || enq1_valid) && !enq_ready);
  end

  // A partially invalid dual issue still retires the valid head0 part.
  always_comb begin
    w_n_deq = '0;
    if (issue0 && head0_valid) w_n_deq = (issue1 && head1_valid) ? CW'(2) : CW'(1);
    w_deq_err = (issue1 && !issue0) || (issue0 && !head0_valid) || (issue1 && !head1_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_n_deq);
      r_wr_ptr <= r_wr_ptr + PW'(w_n_enq);
      r_count  <= r_count + w_n_enq - w_n_deq;
      if (w_enq_err || w_deq_err) r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && w_n_enq != '0) begin
      r_mem[r_wr_ptr] <= enq0_data;
      if (w_n_enq == CW'(2)) r_mem[r_wr_ptr + PW'(1)] <= enq1_data;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Decoded-instruction buffer between the dual decode stage and the dual-issue control unit; it is the producer side of that unit's inst0/inst1 interface.
- Accepts up to two decoded instructions per cycle in program order.
- Presents the two oldest entries as inst0 (head0) and inst1 (head1).
- Retires 0, 1 or 2 entries per cycle, as directed by the issue unit's issue_inst0/issue_inst1 decision.
- Flushes on pipeline redirect (branch or halt).

Parameters:
- DEPTH, 8: number of entries; must be a power of two and at least 4.
- ENTRY_W, 64: width of one packed decoded-instruction payload (opaque to this block).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  discard all entries (redirect).
- enq0_valid  input  1  slot-0 decoded instruction present (older).
- enq0_data  input  ENTRY_W  slot-0 payload.
- enq1_valid  input  1  slot-1 decoded instruction present (younger).
- enq1_data  input  ENTRY_W  slot-1 payload.
- enq_ready  output  1  queue can accept two entries this cycle.
- head0_valid  output  1  oldest entry valid (feeds the issue unit's inst0_valid).
- head0_data  output  ENTRY_W  oldest payload.
- head1_valid  output  1  second-oldest entry valid (feeds inst1_valid).
- head1_data  output  ENTRY_W  second-oldest payload.
- issue0  input  1  issue unit retired head0 this cycle.
- issue1  input  1  issue unit retired head1 this cycle (dual issue).
- count  output  $clog2(DEPTH+1)  current occupancy.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n low, asynchronous): read pointer, write pointer and count = 0; head0_valid = head1_valid = 0; enq_ready = 1; proto_err = 0. Storage is not reset.
- Storage is a circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH by natural overflow.
- Head outputs are combinational from storage and count:
  - head0_valid = (count >= 1); head1_valid = (count >= 2).
  - head0_data = entry at rd_ptr; head1_data = entry at rd_ptr+1 (mod DEPTH).
  - Each head data output is forced to 0 when its valid is low.
- enq_ready = ((DEPTH - count) >= 2). It is computed from the registered count only; a same-cycle dequeue does not raise it (no ready/dequeue combinational path).
- Enqueue, accepted only when enq_ready = 1:
  - enq0_valid alone: write enq0_data at wr_ptr; wr_ptr += 1.
  - enq0_valid and enq1_valid: write enq0_data at wr_ptr and enq1_data at wr_ptr+1; wr_ptr += 2.
  - enq1_valid without enq0_valid: ignored; set proto_err.
  - Any enq*_valid while enq_ready = 0: dropped; set proto_err. The producer must hold its data.
- Dequeue:
  - issue0 alone: rd_ptr += 1, if head0_valid.
  - issue0 and issue1: rd_ptr += 2, if head1_valid.
  - issue1 without issue0: ignored; set proto_err.
  - issue0 with head0_valid = 0, or issue1 with head1_valid = 0: the invalid part is ignored; set proto_err.
- Simultaneous enqueue and dequeue are both applied in the same cycle: count_next = count + n_enq - n_deq, with each term in {0,1,2}. No bypass: a newly enqueued entry appears on the head outputs no earlier than the next cycle, so enqueue-to-head latency is 1 cycle.
- Wrap-around: a dual enqueue at wr_ptr = DEPTH-1 writes index DEPTH-1 and index 0. A dual dequeue at rd_ptr = DEPTH-1 behaves the same way for reads.
- Flush has priority over enqueue and dequeue in the same cycle. Next cycle: rd_ptr = wr_ptr = 0, count = 0, both head valids 0. Same-cycle enq/issue are discarded without setting proto_err. proto_err is unchanged by flush.
- proto_err is sticky and cleared only by reset.
- count never exceeds DEPTH and never goes below 0. The rules above guarantee both; add an assertion in simulation.

Test Plan:
- Reset, then dual-enqueue A,B → next cycle count=2, head0=A, head1=B, enq_ready=1. Then issue0+issue1 → next cycle count=0, both valids 0.
- DEPTH=8: enqueue 7 entries singly → enq_ready=0 at count=7. A further enq0_valid is dropped, proto_err=1, and count stays 7.
- Fill to 6 (enq_ready=1), then dual enqueue with issue0 in the same cycle → count=7. Entries stay in order across pointer wrap at indices 7→0 and 0→1.
- Head 0x11/0x22 with count=2; assert issue0 only → next head0=0x22, head1_valid=0, head1_data=0.
- count=5; assert flush together with dual enqueue and issue0 → next cycle count=0, enq_ready=1, proto_err=0.
- Assert issue1 alone with count=3 → count stays 3, proto_err=1. Then assert rst_n low mid-cycle → all outputs return to reset values immediately (asynchronous).
